// File: rtl/booth_div_pkg.sv
// Shared types and default sizes for the sequential signed divider.
package booth_div_pkg;

  localparam int unsigned DEF_N = 8;
  localparam int unsigned DEF_D = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : booth_div_pkg

// File: rtl/booth_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface booth_divider_if
  import booth_div_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned D = DEF_D
);

  logic         start;
  logic [N-1:0] dividend;
  logic [D-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [D-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface : booth_divider_if

// File: rtl/booth_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor magnitude when it fits.
module booth_div_step
  import booth_div_pkg::*;
#(
  parameter int unsigned D = DEF_D
) (
  input  logic [D:0]   p_in,
  input  logic         a_msb,
  input  logic [D-1:0] div_mag,
  output logic [D:0]   p_out,
  output logic         q_bit
);

  logic [D+1:0] shifted;
  logic [D:0]   diff;

  // Compare the shifted partial remainder against |divisor| and restore on miss.
  always_comb begin
    shifted = {p_in, a_msb};
    diff    = shifted[D:0] - {1'b0, div_mag};
    q_bit   = 1'b0;
    p_out   = shifted[D:0];
    if (shifted >= {2'b00, div_mag}) begin
      q_bit = 1'b1;
      p_out = diff;
    end
  end

endmodule : booth_div_step

// File: rtl/booth_divider.sv
// Sequential signed divider: magnitudes are divided by restoring division,
// one quotient bit per clock, then signs are reapplied on the way out.
module booth_divider
  import booth_div_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned D = DEF_D
) (
  input logic              clk,
  input logic              rst,
  booth_divider_if.slave   bus
);

  localparam int unsigned CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [D:0]    p_q, p_d;
  logic [D-1:0]  dmag_q, dmag_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          zero_div_q, zero_div_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [D-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [D:0]    step_p;
  logic          step_q;

  booth_div_step #(.D(D)) u_step (
    .p_in    (p_q),
    .a_msb   (a_q[N-1]),
    .div_mag (dmag_q),
    .p_out   (step_p),
    .q_bit   (step_q)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    p_d        = p_q;
    dmag_d     = dmag_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    zero_div_d = zero_div_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_CALC;
          busy_d     = 1'b1;
          cnt_d      = '0;
          p_d        = '0;
          a_d        = bus.dividend[N-1] ? N'(~bus.dividend + N'(1)) : bus.dividend;
          dmag_d     = bus.divisor[D-1] ? D'(~bus.divisor + D'(1)) : bus.divisor;
          neg_quo_d  = bus.dividend[N-1] ^ bus.divisor[D-1];
          neg_rem_d  = bus.dividend[N-1];
          zero_div_d = (bus.divisor == '0);
        end
      end

      ST_CALC: begin
        busy_d = 1'b1;
        p_d    = step_p;
        a_d    = {a_q[N-2:0], step_q};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (zero_div_q) begin
          quo_d = '1;
          rem_d = '0;
          dbz_d = 1'b1;
        end else begin
          // |r| < |divisor| <= 2^(D-1), so the low D bits hold it exactly.
          quo_d = neg_quo_q ? N'(~a_q + N'(1)) : a_q;
          rem_d = neg_rem_q ? D'(~p_q[D-1:0] + D'(1)) : p_q[D-1:0];
          dbz_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      p_q        <= '0;
      dmag_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      p_q        <= p_d;
      dmag_q     <= dmag_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule : booth_divider

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider (N=8, D=4) with hand-computed vectors.
module tb_booth_divider;

  localparam int unsigned N   = 8;
  localparam int unsigned D   = 4;
  localparam int          LAT = N + 1;

  typedef struct packed {
    logic [N-1:0] q;
    logic [D-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rst;

  booth_divider_if #(.N(N), .D(D)) bus ();

  booth_divider #(.N(N), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pop an expectation for every done pulse and compare results.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pulse at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("quotient", 32'(bus.quotient), 32'(e.q));
          check("remainder", 32'(bus.remainder), 32'(e.r));
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        end
      end
    end
  end

  // Issue one divide, check handshake timing and result hold afterwards.
  task automatic do_div(input logic [N-1:0] a, input logic [D-1:0] b,
                        input logic [N-1:0] eq, input logic [D-1:0] er, input logic edbz);
    exp_t e;
    int   k;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    exp_q.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_latency", 32'(k), 32'(LAT));
    check("busy_with_done", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("done_single_pulse", 32'(bus.done), 32'd0);
    check("quotient_hold", 32'(bus.quotient), 32'(eq));
    check("remainder_hold", 32'(bus.remainder), 32'(er));
  endtask

  initial begin
    int k;
    int done_base;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: dividend, divisor, quotient, remainder, dbz.
    do_div(8'd24,   4'd6,  8'd4,   4'd0,  1'b0);   //   24 /  6 =   4 r  0
    do_div(8'hE0,   4'h8,  8'd4,   4'd0,  1'b0);   //  -32 / -8 =   4 r  0
    do_div(8'd127,  4'hB,  8'hE7,  4'd2,  1'b0);   //  127 / -5 = -25 r  2
    do_div(8'h81,   4'd5,  8'hE7,  4'hE,  1'b0);   // -127 /  5 = -25 r -2
    do_div(8'd7,    4'd0,  8'hFF,  4'd0,  1'b1);   //    7 /  0 -> dbz
    do_div(8'h80,   4'hF,  8'h80,  4'd0,  1'b0);   // -128 / -1 wraps
    do_div(8'hF9,   4'd2,  8'hFD,  4'hF,  1'b0);   //   -7 /  2 =  -3 r -1
    do_div(8'd100,  4'd7,  8'd14,  4'd2,  1'b0);   //  100 /  7 =  14 r  2
    do_div(8'd5,    4'h8,  8'd0,   4'd5,  1'b0);   //    5 / -8 =   0 r  5
    do_div(8'hFF,   4'd3,  8'd0,   4'hF,  1'b0);   //   -1 /  3 =   0 r -1

    // Start pulsed during CALC must be ignored.
    done_base = done_cnt;
    exp_q.push_back('{q: 8'd4, r: 4'd0, dbz: 1'b0});
    bus.start    = 1'b1;
    bus.dividend = 8'd24;
    bus.divisor  = 4'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 2) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd3;
      end else if (k == 3) begin
        bus.start = 1'b0;
      end
    end
    check("ignored_start_latency", 32'(k), 32'(LAT));
    repeat (14) @(posedge clk);
    #1;
    check("ignored_start_one_done", 32'(done_cnt - done_base), 32'd1);
    check("ignored_start_idle", 32'(bus.busy), 32'd0);

    // Reset mid-divide abandons it without a done pulse.
    done_base    = done_cnt;
    bus.start    = 1'b1;
    bus.dividend = 8'd24;
    bus.divisor  = 4'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_quotient", 32'(bus.quotient), 32'd0);
    check("midrst_remainder", 32'(bus.remainder), 32'd0);
    check("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - done_base), 32'd0);

    do_div(8'd24, 4'd6, 8'd4, 4'd0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_booth_divider
